// File: rtl/serial_add_unit.sv
// serial_add_unit: bit-serial adder stage built around one sc2_block full-adder cell.
// Two WIDTH-bit operands are captured on an accepted start. One bit pair is added per
// cycle, LSB first, with a registered carry fed back into the cell. The registered sum
// and carry-out are published together with a one-cycle done pulse.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   start    operation request, sampled only in IDLE
//   a_in     operand A, captured on an accepted start
//   b_in     operand B, captured on an accepted start
//   busy     high while an operation is in RUN or DONE
//   done     one-cycle pulse, sum_out/c_out valid
//   sum_out  (A+B) mod 2^WIDTH, held until the next completion
//   c_out    carry-out of the MSB add, held until the next completion

// sc2_block: single-bit full adder cell.
module sc2_block (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s_out,
  output logic c_out
);

  assign s_out = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

module serial_add_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             cy;
  logic [CNT_W-1:0] cnt;

  logic             cell_s;
  logic             cell_c;
  logic [WIDTH-1:0] s_shift_c;

  logic             load_c;
  logic             shift_c;
  logic             finish_c;

  // Adder cell: current LSBs of both operands plus the carry from the previous bit.
  sc2_block u_cell (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (cy),
    .s_out (cell_s),
    .c_out (cell_c)
  );

  // New sum bit enters at the MSB. The concatenation form stays legal for WIDTH==1.
  assign s_shift_c = WIDTH'({cell_s, s_sh} >> 1);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST_BIT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath control strobes decoded from the current state.
  always_comb begin
    load_c   = 1'b0;
    shift_c  = 1'b0;
    finish_c = 1'b0;
    case (state)
      IDLE: load_c = start;
      RUN: begin
        shift_c  = 1'b1;
        finish_c = (cnt == LAST_BIT);
      end
      default: ;
    endcase
  end

  // Status flags registered from the next state so they track the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
    end
  end

  // Operand/sum shift registers, carry loop and bit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sh <= '0;
      b_sh <= '0;
      s_sh <= '0;
      cy   <= 1'b0;
      cnt  <= '0;
    end else if (load_c) begin
      a_sh <= a_in;
      b_sh <= b_in;
      s_sh <= '0;
      cy   <= 1'b0;
      cnt  <= '0;
    end else if (shift_c) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      s_sh <= s_shift_c;
      cy   <= cell_c;
      cnt  <= cnt + CNT_W'(1);
    end
  end

  // Result registers update only on the completing edge, then hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_out <= '0;
      c_out   <= 1'b0;
    end else if (finish_c) begin
      sum_out <= s_shift_c;
      c_out   <= cell_c;
    end
  end

endmodule

// File: tb/tb_serial_add_unit.sv
module tb_serial_add_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       co8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       co4;

  int checks = 0;
  int errors = 0;

  logic [8:0] q8[$];
  logic [4:0] q4[$];

  always #5 clk = ~clk;

  serial_add_unit #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .reset   (rst),
    .start   (start8),
    .a_in    (a8),
    .b_in    (b8),
    .busy    (busy8),
    .done    (done8),
    .sum_out (sum8),
    .c_out   (co8)
  );

  serial_add_unit #(.WIDTH(4)) dut4 (
    .clk     (clk),
    .reset   (rst),
    .start   (start4),
    .a_in    (a4),
    .b_in    (b4),
    .busy    (busy4),
    .done    (done4),
    .sum_out (sum4),
    .c_out   (co4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request one 8-bit operation and record its expected result.
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = 9'(a) + 9'(b);
    a8 = a;
    b8 = b;
    start8 = 1'b1;
    q8.push_back(s);
    tick();
    start8 = 1'b0;
    check("busy_after_start", 32'(busy8), 32'd1);
  endtask

  // Wait for done (bounded); compare latency, busy time and popped expected result.
  task automatic wait_done8(input string tag, input int exp_cycles);
    int cyc;
    int busy_n;
    logic [8:0] e;
    cyc = 0;
    busy_n = 1;
    while (!done8 && cyc < 40) begin
      tick();
      cyc++;
      if (busy8) busy_n++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_cycles));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_cycles + 1));
    if (q8.size() > 0) e = q8.pop_front();
    else e = 'x;
    check({tag, "_result"}, 32'({co8, sum8}), 32'(e));
  endtask

  initial begin
    int cyc;
    int done_seen;
    logic [4:0] e4;

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_sum", 32'(sum8), 32'd0);
    check("rst_cout", 32'(co8), 32'd0);
    rst = 1'b1;
    tick();

    // 1: 0x5A + 0x33
    start_op8(8'h5A, 8'h33);
    wait_done8("t1", 8);
    tick();
    check("t1_done_pulse", 32'(done8), 32'd0);
    check("t1_idle_busy", 32'(busy8), 32'd0);

    // 2: overflow cases; previous result holds during the next operation
    start_op8(8'hFF, 8'h01);
    wait_done8("t2a", 8);
    tick();
    start_op8(8'hFF, 8'hFF);
    tick();
    tick();
    check("t2_hold", 32'({co8, sum8}), 32'h100);
    wait_done8("t2b", 6);
    tick();

    // 3: start re-asserted during RUN and DONE is ignored
    start_op8(8'h10, 8'h20);
    tick();
    a8 = 8'hAA;
    b8 = 8'hAA;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done8("t3", 6);
    a8 = 8'hAA;
    b8 = 8'hAA;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("t3_no_recapture_busy", 32'(busy8), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done8) done_seen++;
    end
    check("t3_single_done", 32'(done_seen), 32'd0);
    check("t3_result_held", 32'({co8, sum8}), 32'h030);

    // 4: start held high -> back-to-back operations, one idle cycle between
    a8 = 8'h01;
    b8 = 8'h02;
    start8 = 1'b1;
    q8.push_back(9'h003);
    tick();
    for (int k = 0; k < 3; k++) begin
      wait_done8("t4", 8);
      if (k < 2) q8.push_back(9'h003);
      else start8 = 1'b0;
      tick();
      check("t4_gap_busy", 32'(busy8), 32'd0);
      check("t4_gap_done", 32'(done8), 32'd0);
      tick();
      check("t4_restart_busy", 32'(busy8), (k < 2) ? 32'd1 : 32'd0);
    end

    // 5: asynchronous reset mid-RUN abandons the operation
    a8 = 8'h3C;
    b8 = 8'h11;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy8), 32'd0);
    check("t5_rst_done", 32'(done8), 32'd0);
    check("t5_rst_sum", 32'(sum8), 32'd0);
    check("t5_rst_cout", 32'(co8), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done8 || busy8) done_seen++;
    end
    check("t5_no_done_after_rst", 32'(done_seen), 32'd0);
    start_op8(8'h07, 8'h09);
    wait_done8("t5", 8);
    tick();

    // 6: exhaustive WIDTH=4
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        a4 = 4'(a);
        b4 = 4'(b);
        start4 = 1'b1;
        q4.push_back(5'(a) + 5'(b));
        tick();
        start4 = 1'b0;
        cyc = 0;
        while (!done4 && cyc < 20) begin
          tick();
          cyc++;
        end
        check("t6_latency", 32'(cyc), 32'd4);
        if (q4.size() > 0) e4 = q4.pop_front();
        else e4 = 'x;
        check("t6_result", 32'({co4, sum4}), 32'(e4));
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
